// File: rtl/code_lock_ctrl_if.sv
// rtl/code_lock_ctrl_if.sv - Start/Match inputs and lock-drive outputs of the attempt sequencer
interface code_lock_ctrl_if;
   logic       Start;
   logic       Match;
   logic       DetStart;
   logic       DetRst;
   logic       Unlock;
   logic       Alarm;
   logic       Busy;
   logic [1:0] FailCnt;

   modport master (
      output Start, Match,
      input  DetStart, DetRst, Unlock, Alarm, Busy, FailCnt
   );

   modport slave (
      input  Start, Match,
      output DetStart, DetRst, Unlock, Alarm, Busy, FailCnt
   );
endinterface

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - attempt sequencer for the colour-code lock
// Bounds each attempt, counts consecutive failures, drives unlock and lockout.
module code_lock_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int UNLOCK_CYCLES  = 8,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   code_lock_ctrl_if.slave  bus
);

   localparam int MAX_AB  = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
   localparam int TW      = $clog2(MAX_CYC) + 1;

   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] UN_LAST = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LO_LAST = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]    MAX_F   = 2'(MAX_FAILS);

   typedef enum logic [2:0] {
      S_Idle,
      S_Attempt,
      S_Open,
      S_Clear,
      S_Lockout
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic [TW-1:0] w_timer_inc;
   logic [1:0]    r_fail;
   logic [1:0]    w_fail_nxt;
   logic [1:0]    w_fail_inc;

   assign w_timer_inc = r_timer + TW'(1);
   assign w_fail_inc  = (r_fail == MAX_F) ? r_fail : r_fail + 2'd1;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_Idle;
         r_timer <= '0;
         r_fail  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_fail  <= w_fail_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_fail_nxt  = r_fail;
      case (r_state)
         S_Idle: begin
            if (bus.Start) begin
               w_state_nxt = S_Attempt;
               w_timer_nxt = '0;
            end
         end
         S_Attempt: begin
            w_timer_nxt = w_timer_inc;
            // A match on the final attempt cycle still counts as success.
            if (bus.Match) begin
               w_state_nxt = S_Open;
               w_fail_nxt  = 2'd0;
               w_timer_nxt = '0;
            end else if (r_timer == TO_LAST) begin
               w_fail_nxt  = w_fail_inc;
               w_state_nxt = (w_fail_inc == MAX_F) ? S_Lockout : S_Clear;
               w_timer_nxt = '0;
            end
         end
         S_Open: begin
            w_timer_nxt = w_timer_inc;
            if (r_timer == UN_LAST) begin
               w_state_nxt = S_Clear;
               w_timer_nxt = '0;
            end
         end
         S_Clear: begin
            w_state_nxt = S_Idle;
            w_timer_nxt = '0;
         end
         S_Lockout: begin
            w_timer_nxt = w_timer_inc;
            if (r_timer == LO_LAST) begin
               w_state_nxt = S_Idle;
               w_fail_nxt  = 2'd0;
               w_timer_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_Idle;
            w_timer_nxt = '0;
         end
      endcase
   end

   assign bus.Unlock   = (r_state == S_Open);
   assign bus.Alarm    = (r_state == S_Lockout);
   assign bus.DetRst   = (r_state == S_Clear) || (r_state == S_Lockout);
   assign bus.Busy     = (r_state != S_Idle);
   assign bus.DetStart = bus.Start && (r_state == S_Idle);
   assign bus.FailCnt  = r_fail;

endmodule
